// File: rtl/sram_burst_reader.sv
// Burst read engine for an asynchronous-read register file: walks the read address and emits a valid/ready word stream.
// Optional XOR checksum of each burst is built only when SRAM_BURST_READER_CHECKSUM_EN is defined.
module sram_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddress,
  input  logic [ADDR_WIDTH:0]   burstLength,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic [DATA_WIDTH-1:0] streamData,
  output logic                  streamValid,
  input  logic                  streamReady,
  output logic                  streamLast,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  // state  | meaning
  // S_IDLE | waiting for start; done pulses here
  // S_READ | capturing words from memory while the output slot can take one
  // S_DRAIN| last word captured, waiting for its transfer
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH:0]   len_eff;
  logic                  load;
  logic                  xfer;

  // Out-of-range lengths saturate to a full sweep of the memory.
  assign len_eff = (burstLength > DEPTH) ? DEPTH : burstLength;
  assign load    = !valid_q || streamReady;
  assign xfer    = valid_q && streamReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (len_eff != '0)) state_d = S_READ;
      S_READ:  if (load && (rem_q == ONE)) state_d = S_DRAIN;
      S_DRAIN: if (xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_eff != '0) begin
            addr_d = startAddress;
            rem_d  = len_eff;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (load) begin
          data_d  = readData;
          valid_d = 1'b1;
          last_d  = (rem_q == ONE);
          addr_d  = addr_q + ADDR_WIDTH'(1);
          rem_d   = rem_q - ONE;
        end
      end
      S_DRAIN: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign readAddress = addr_q;
  assign streamData  = data_q;
  assign streamValid = valid_q;
  assign streamLast  = last_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);

`ifdef SRAM_BURST_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if ((state_q == S_IDLE) && start) chk_d = '0;
    else if (xfer) chk_d = chk_q ^ data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) chk_q <= '0;
    else       chk_q <= chk_d;
  end

  assign checksum = chk_q;
`else
  assign checksum = '0;
`endif

endmodule
